// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen
//   Builds RMT control packets. A request (module id, table index, payload
//   beat count) is latched, then one 512-bit header beat is emitted. After
//   it, 0..7 payload words are passed straight from cfg_data to the output
//   stream. There is no internal buffering. Payload words are stalled,
//   never dropped, until the header has been accepted.
//
// Ports
//   clk, areset        clock, synchronous active-high reset
//   req_*              request handshake and fields (mod_id, idx, nbeats)
//   cfg_data*          payload word stream (valid/ready)
//   m_axis_*           AXI-Stream master output (tdata/tkeep/tuser/tlast)
//   pkt_cnt            number of fully sent packets, wraps at 2^32
module ctrl_pkt_gen #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 512,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_DPORT           = 16'hf1f2
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [3:0]                        req_mod_id,
  input  logic [7:0]                        req_idx,
  input  logic [2:0]                        req_nbeats,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    cfg_data,
  input  logic                              cfg_data_valid,
  output logic                              cfg_data_ready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]  state_reg,  state_next;
  logic [3:0]  mod_id_reg, mod_id_next;
  logic [7:0]  idx_reg,    idx_next;
  logic [2:0]  nbeats_reg, nbeats_next;
  logic [2:0]  beat_reg,   beat_next;
  logic [31:0] pkt_cnt_reg, pkt_cnt_next;

  logic                             last_beat;
  logic [15:0]                      hdr_len;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   hdr_data;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  hdr_user;

  // Only meaningful in PAYLOAD, where nbeats_reg is at least 1.
  assign last_beat = (beat_reg == (nbeats_reg - 3'd1));

  // Byte length of the whole packet: 64 * (nbeats + 1).
  assign hdr_len = {6'd0, ({1'b0, nbeats_reg} + 4'd1), 6'd0};

  // The header is built only from the latched request registers. It
  // therefore stays stable while stalled, even if req_* keep changing.
  always_comb begin
    hdr_data          = '0;
    hdr_data[143:128] = 16'h0008;
    hdr_data[223:216] = 8'h11;
    hdr_data[335:320] = CTRL_DPORT;
    hdr_data[383:380] = mod_id_reg;
    hdr_data[379:376] = 4'h0;
    hdr_data[375:368] = idx_reg;
    hdr_user          = '0;
    hdr_user[15:0]    = hdr_len;
  end

  always_comb begin
    state_next   = state_reg;
    mod_id_next  = mod_id_reg;
    idx_next     = idx_reg;
    nbeats_next  = nbeats_reg;
    beat_next    = beat_reg;
    pkt_cnt_next = pkt_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          mod_id_next = req_mod_id;
          idx_next    = req_idx;
          nbeats_next = req_nbeats;
          state_next  = HDR;
        end
      end
      HDR: begin
        if (m_axis_tready) begin
          beat_next = '0;
          if (nbeats_reg == 3'd0) begin
            state_next   = IDLE;
            pkt_cnt_next = pkt_cnt_reg + 32'd1;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (cfg_data_valid && m_axis_tready) begin
          beat_next = beat_reg + 3'd1;
          if (last_beat) begin
            state_next   = IDLE;
            pkt_cnt_next = pkt_cnt_reg + 32'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_reg   <= IDLE;
      mod_id_reg  <= '0;
      idx_reg     <= '0;
      nbeats_reg  <= '0;
      beat_reg    <= '0;
      pkt_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mod_id_reg  <= mod_id_next;
      idx_reg     <= idx_next;
      nbeats_reg  <= nbeats_next;
      beat_reg    <= beat_next;
      pkt_cnt_reg <= pkt_cnt_next;
    end
  end

  // Output mux. PAYLOAD is a pure combinational pass-through, so the
  // valid/ready pair of the payload source sees the downstream directly.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    cfg_data_ready = 1'b0;
    case (state_reg)
      HDR: begin
        m_axis_tdata  = hdr_data;
        m_axis_tkeep  = '1;
        m_axis_tuser  = hdr_user;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (nbeats_reg == 3'd0);
      end
      PAYLOAD: begin
        m_axis_tdata   = cfg_data;
        m_axis_tkeep   = '1;
        m_axis_tvalid  = cfg_data_valid;
        m_axis_tlast   = last_beat;
        cfg_data_ready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_reg == IDLE) && !areset;
  assign pkt_cnt   = pkt_cnt_reg;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb_ctrl_pkt_gen
//   Directed bench for ctrl_pkt_gen. A transaction-level model tracks the
//   packet in flight. It knows whether a packet is open, whether its header
//   is still pending, and how many payload beats are left. Every cycle, on
//   the falling edge, all DUT outputs are checked against that model.
//   Literal expectations pin the header layout and the packet counts.
module tb_ctrl_pkt_gen;

  logic         clk = 1'b0;
  logic         areset;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_mod_id;
  logic [7:0]   req_idx;
  logic [2:0]   req_nbeats;
  logic [511:0] cfg_data;
  logic         cfg_data_valid;
  logic         cfg_data_ready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  pkt_cnt;

  always #5 clk = ~clk;

  ctrl_pkt_gen dut (
    .clk            (clk),
    .areset         (areset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mod_id     (req_mod_id),
    .req_idx        (req_idx),
    .req_nbeats     (req_nbeats),
    .cfg_data       (cfg_data),
    .cfg_data_valid (cfg_data_valid),
    .cfg_data_ready (cfg_data_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .pkt_cnt        (pkt_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Transaction model state.
  bit          m_known = 0;  // set once a reset edge has been seen
  bit          m_busy  = 0;  // a packet is open
  bit          m_hdr   = 0;  // its header has not yet been accepted
  int          m_mod, m_idx, m_nb, m_left;
  logic [31:0] m_cnt = '0;
  bit          cnt_preload = 0;
  int          hs_cnt = 0;    // output handshakes seen
  int          last_cnt = 0;  // tlast handshakes seen

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] hdr_word(input int mod, input int idx);
    logic [511:0] w;
    w          = '0;
    w[143:128] = 16'h0008;
    w[223:216] = 8'h11;
    w[335:320] = 16'hf1f2;
    w[383:380] = mod[3:0];
    w[375:368] = idx[7:0];
    return w;
  endfunction

  task automatic compare_all();
    logic [511:0] e_data;
    logic [63:0]  e_keep;
    logic [127:0] e_user;
    logic e_valid, e_last, e_cready, e_rready;
    e_data = '0; e_keep = '0; e_user = '0;
    e_valid = 1'b0; e_last = 1'b0; e_cready = 1'b0;
    e_rready = !m_busy && !areset;
    if (m_busy && m_hdr) begin
      e_valid = 1'b1;
      e_data  = hdr_word(m_mod, m_idx);
      e_keep  = '1;
      e_user  = 128'(64 * (m_nb + 1));
      e_last  = (m_nb == 0);
    end else if (m_busy) begin
      e_data   = cfg_data;
      e_valid  = cfg_data_valid;
      e_cready = m_axis_tready;
      e_keep   = '1;
      e_last   = (m_left == 1);
    end
    if (m_known) begin
      chk("tvalid", 512'(m_axis_tvalid), 512'(e_valid));
      chk("tdata", m_axis_tdata, e_data);
      chk("tkeep", 512'(m_axis_tkeep), 512'(e_keep));
      chk("tuser", 512'(m_axis_tuser), 512'(e_user));
      chk("tlast", 512'(m_axis_tlast), 512'(e_last));
      chk("cfg_ready", 512'(cfg_data_ready), 512'(e_cready));
      chk("req_ready", 512'(req_ready), 512'(e_rready));
      if (!cnt_preload) chk("pkt_cnt", 512'(pkt_cnt), 512'(m_cnt));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      hs_cnt++;
      if (m_axis_tlast) last_cnt++;
    end
  endtask

  task automatic model_update();
    if (areset) begin
      m_known = 1; m_busy = 0; m_hdr = 0; m_cnt = '0;
    end else if (m_known) begin
      if (cnt_preload) m_cnt = 32'hffff_ffff;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_hdr = 1;
          m_mod = int'(req_mod_id); m_idx = int'(req_idx); m_nb = int'(req_nbeats);
          m_left = m_nb;
        end
      end else if (m_hdr) begin
        if (m_axis_tready) begin
          m_hdr = 0;
          if (m_nb == 0) begin m_busy = 0; m_cnt = m_cnt + 32'd1; end
        end
      end else if (cfg_data_valid && m_axis_tready) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_busy = 0; m_cnt = m_cnt + 32'd1; end
      end
    end
  endtask

  // One clock: check outputs on the falling edge, advance the model on the
  // rising edge, return 1 ns later so new inputs are driven away from it.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic request(input logic [3:0] mod, input logic [7:0] idx, input logic [2:0] nb);
    req_valid = 1'b1; req_mod_id = mod; req_idx = idx; req_nbeats = nb;
    cycle();
    req_valid = 1'b0;
  endtask

  int hs0, last0;

  initial begin
    areset = 1'b1; req_valid = 1'b0; req_mod_id = '0; req_idx = '0; req_nbeats = '0;
    cfg_data = '0; cfg_data_valid = 1'b0; m_axis_tready = 1'b1;
    repeat (3) cycle();
    chk("rst_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_req_ready", 512'(req_ready), 512'(0));
    chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
    areset = 1'b0;
    cycle();
    chk("idle_req_ready", 512'(req_ready), 512'(1));

    // Basic: mod 2, idx 2, three payload beats.
    request(4'd2, 8'h02, 3'd3);
    #1;
    chk("basic_hdr_id", 512'(m_axis_tdata[383:368]), 512'(16'h2002));
    chk("basic_hdr_dport", 512'(m_axis_tdata[335:320]), 512'(16'hf1f2));
    chk("basic_hdr_proto", 512'(m_axis_tdata[223:216]), 512'(8'h11));
    chk("basic_hdr_type", 512'(m_axis_tdata[143:128]), 512'(16'h0008));
    chk("basic_hdr_len", 512'(m_axis_tuser[15:0]), 512'(256));
    chk("basic_hdr_last", 512'(m_axis_tlast), 512'(0));
    cycle();
    cfg_data = 512'h3ffff; cfg_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("basic_beat_last", 512'(m_axis_tlast), 512'(i == 2));
      cycle();
    end
    cfg_data_valid = 1'b0;
    chk("basic_pkt_cnt", 512'(pkt_cnt), 512'(1));

    // Header-only packet.
    request(4'd1, 8'h01, 3'd0);
    #1;
    chk("hdronly_last", 512'(m_axis_tlast), 512'(1));
    chk("hdronly_len", 512'(m_axis_tuser[15:0]), 512'(64));
    cycle();
    chk("hdronly_pkt_cnt", 512'(pkt_cnt), 512'(2));
    chk("hdronly_idle", 512'(req_ready), 512'(1));

    // Backpressure on the header and on the first payload beat.
    hs0 = hs_cnt; last0 = last_cnt;
    request(4'd7, 8'hab, 3'd2);
    m_axis_tready = 1'b0;
    repeat (3) cycle();
    m_axis_tready = 1'b1;
    cycle();
    cfg_data = {16{32'hdead_0001}}; cfg_data_valid = 1'b1; m_axis_tready = 1'b0;
    #1;
    chk("bp_cfg_ready_low", 512'(cfg_data_ready), 512'(0));
    repeat (2) cycle();
    m_axis_tready = 1'b1;
    cycle();
    cfg_data = {16{32'hbeef_0002}};
    cycle();
    cfg_data_valid = 1'b0;
    chk("bp_beats", 512'(hs_cnt - hs0), 512'(3));
    chk("bp_lasts", 512'(last_cnt - last0), 512'(1));

    // Early payload, offered together with the request.
    cfg_data = {8{64'h0123_4567_89ab_cdef}}; cfg_data_valid = 1'b1;
    req_valid = 1'b1; req_mod_id = 4'd4; req_idx = 8'h10; req_nbeats = 3'd1;
    #1;
    chk("early_ready_idle", 512'(cfg_data_ready), 512'(0));
    cycle();
    req_valid = 1'b0;
    #1;
    chk("early_ready_hdr", 512'(cfg_data_ready), 512'(0));
    cycle();
    #1;
    chk("early_data", m_axis_tdata, {8{64'h0123_4567_89ab_cdef}});
    cycle();
    cfg_data_valid = 1'b0;
    chk("early_pkt_cnt", 512'(pkt_cnt), 512'(4));

    // Back-to-back: request held, fields changed mid-packet.
    req_valid = 1'b1; req_mod_id = 4'd3; req_idx = 8'h44; req_nbeats = 3'd1;
    cycle();
    req_mod_id = 4'd5; req_idx = 8'h55; req_nbeats = 3'd2;
    #1;
    chk("b2b_hdr1", 512'(m_axis_tdata[383:368]), 512'(16'h3044));
    chk("b2b_busy_ready", 512'(req_ready), 512'(0));
    cycle();
    cfg_data = 512'h1111; cfg_data_valid = 1'b1;
    cycle();
    cfg_data_valid = 1'b0;
    chk("b2b_gap_ready", 512'(req_ready), 512'(1));
    chk("b2b_gap_valid", 512'(m_axis_tvalid), 512'(0));
    cycle();
    req_valid = 1'b0;
    #1;
    chk("b2b_hdr2", 512'(m_axis_tdata[383:368]), 512'(16'h5055));
    chk("b2b_len2", 512'(m_axis_tuser[15:0]), 512'(192));
    cycle();
    cfg_data = 512'h2222; cfg_data_valid = 1'b1;
    repeat (2) cycle();
    cfg_data_valid = 1'b0;
    chk("b2b_pkt_cnt", 512'(pkt_cnt), 512'(6));

    // Reset after one of three payload beats.
    request(4'd6, 8'h66, 3'd3);
    cycle();
    cfg_data = 512'h3333; cfg_data_valid = 1'b1;
    cycle();
    areset = 1'b1; cfg_data_valid = 1'b0;
    cycle();
    chk("rst_mid_valid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_mid_pkt_cnt", 512'(pkt_cnt), 512'(0));
    areset = 1'b0;
    cycle();
    request(4'd8, 8'h88, 3'd1);
    cycle();
    cfg_data = 512'h4444; cfg_data_valid = 1'b1;
    cycle();
    cfg_data_valid = 1'b0;
    chk("post_rst_pkt_cnt", 512'(pkt_cnt), 512'(1));

    // Counter wrap.
    force dut.pkt_cnt_reg = 32'hffff_ffff;
    cnt_preload = 1'b1;
    cycle();
    release dut.pkt_cnt_reg;
    cnt_preload = 1'b0;
    cycle();
    chk("wrap_pre", 512'(pkt_cnt), 512'(32'hffff_ffff));
    request(4'd9, 8'h99, 3'd0);
    cycle();
    chk("wrap_post", 512'(pkt_cnt), 512'(0));
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
